// File: rtl/tdm_demux_8bit_pkg.sv
// Shared definitions for the 8:1 TDM mux/demux path.
//   - state encodings for the demux FSM
//   - default word width and slot counter width, reused by the mux and benches
package tdm_demux_8bit_pkg;

    localparam int TDM_WIDTH = 8;   // bits per word == slots per frame
    localparam int TDM_SEL_W = 3;   // log2(TDM_WIDTH)

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demux.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : bit accepted as slot 0 -> counter goes to 1
//   en         : mid-frame bit accepted -> counter increments
//   slot       : registered slot index expected for the next accepted bit
//   wrap       : combinational, high when the accepted bit is the last slot
module tdm_slot_counter
    import tdm_demux_8bit_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] slot,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] slot_reg;
    logic [SEL_W-1:0] slot_next;

    // Load wins over increment; the wrap back to 0 is plain SEL_W-bit overflow.
    always_comb begin
        slot_next = slot_reg;
        wrap      = 1'b0;
        if (load) begin
            slot_next = SLOT_ONE;
        end else if (en) begin
            slot_next = slot_reg + SLOT_ONE;
            wrap      = (slot_reg == SLOT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot = slot_reg;

endmodule

// File: rtl/tdm_demux_8bit.sv
// TDM demultiplexer / deserializer, receiving end of the 8:1 mux path.
//   clk, rst_n  : clock, asynchronous active-low reset
//   serial_in   : muxed data bit
//   bit_valid   : serial_in is sampled this cycle
//   frame_start : current bit is slot 0 (only with bit_valid)
//   slot        : slot expected for the next accepted bit, drives the mux sel
//   out         : reconstructed word, out[k] received in slot k
//   out_valid   : out holds an unconsumed word
//   out_ready   : downstream takes out when high with out_valid
//   frame_err   : pulse, frame_start arrived mid-frame, partial word dropped
//   overrun     : pulse, word completed while holding register full and unread
module tdm_demux_8bit
    import tdm_demux_8bit_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [SEL_W-1:0] slot,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] part_reg, part_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg, overrun_next;

    logic             accept_start;
    logic             accept_bit;
    logic             wrap;
    logic [WIDTH-1:0] slot_hit;
    logic [WIDTH-1:0] steered;

    // A frame_start bit is always taken as slot 0; other bits only count
    // while a frame is being collected.
    assign accept_start = bit_valid & frame_start;
    assign accept_bit   = bit_valid & ~frame_start & (state_reg == ST_COLLECT);

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_start),
        .en    (accept_bit),
        .slot  (slot),
        .wrap  (wrap)
    );

    // Bit steering: the partial word with the current bit dropped into its
    // slot. On the completing cycle this is the finished word.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_steer
        assign slot_hit[gi] = (slot == SEL_W'(gi));
        assign steered[gi]  = (accept_bit & slot_hit[gi]) ? serial_in : part_reg[gi];
    end

    always_comb begin
        state_next     = state_reg;
        part_next      = part_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept_start) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept_start) begin
                    frame_err_next = 1'b1;
                end else if (wrap) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (accept_start) begin
            part_next    = '0;
            part_next[0] = serial_in;
        end else if (wrap) begin
            part_next = '0;
        end else if (accept_bit) begin
            part_next = steered;
        end

        // A full register that is being read this cycle counts as free.
        if (wrap) begin
            if (!out_valid_reg || out_ready) begin
                out_next       = steered;
                out_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            part_reg      <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            part_reg      <= part_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_tdm_demux_8bit.sv
module tb_tdm_demux_8bit;
    import tdm_demux_8bit_pkg::*;

    localparam int W = TDM_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   slot;
    logic [W-1:0] out;
    logic         out_valid;
    logic         frame_err;
    logic         overrun;

    tdm_demux_8bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .slot        (slot),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;

    // Reference model: the frame in progress is just the list of bits received
    // since the last accepted frame_start; its length is the expected slot.
    bit           mq[$];
    logic [W-1:0] m_out;
    bit           m_valid, m_ferr, m_ovr;

    task automatic model_reset();
        mq.delete();
        m_out = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit sv, input bit bv, input bit fs, input bit rdy);
        bit           complete = 0;
        logic [W-1:0] word = '0;
        m_ferr = 0; m_ovr = 0;
        if (bv) begin
            if (fs) begin
                if (mq.size() > 0) m_ferr = 1;
                mq.delete();
                mq.push_back(sv);
            end else if (mq.size() > 0) begin
                mq.push_back(sv);
            end
            if (mq.size() == W) begin
                for (int k = 0; k < W; k++) word[k] = mq[k];
                mq.delete();
                complete = 1;
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_out = word; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge.
    task automatic cycle(input bit sv, input bit bv, input bit fs, input bit rdy);
        serial_in = sv; bit_valid = bv; frame_start = fs; out_ready = rdy;
        model_step(sv, bv, fs, rdy);
        @(posedge clk);
        #1;
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
        check("slot", 32'(slot), 32'(mq.size()));
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send_frame(input logic [W-1:0] word, input bit rdy,
                              input logic [W-1:0] stall_mask, input int stall_len);
        for (int k = 0; k < W; k++) begin
            cycle(word[k], 1'b1, k == 0, rdy);
            if (stall_mask[k] && k != W - 1)
                for (int s = 0; s < stall_len; s++) cycle(1'b0, 1'b0, 1'b0, rdy);
        end
        $display("frame %02h sent ready=%0d -> out=%02h out_valid=%0d", word, rdy, out, out_valid);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] stall_mask;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'hFF, 8'h01, 8'hFF};
        vecs[2] = '{8'h55, 8'h10, 8'h55};
        vecs[3] = '{8'hAA, 8'h00, 8'hAA};
        vecs[4] = '{8'h81, 8'h42, 8'h81};
        vecs[5] = '{8'h7E, 8'h00, 8'h7E};

        model_reset();
        #12;
        check("reset_slot", 32'(slot), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'({frame_err, overrun}), 32'd0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 1);

        // Basic frame 8'b10011010
        send_frame(8'h9A, 1, 8'h00, 0);
        check("basic_out", 32'(out), 32'h9A);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_slot_wrap", 32'(slot), 32'd0);
        cycle(0, 0, 0, 1);
        check("basic_valid_drop", 32'(out_valid), 32'd0);

        // Stalls after slots 2 and 5
        ferr_seen = 0; ovr_seen = 0;
        send_frame(8'h9A, 1, 8'b0010_0100, 3);
        check("stall_out", 32'(out), 32'h9A);
        check("stall_flags", 32'(ferr_seen + ovr_seen), 32'd0);
        cycle(0, 0, 0, 1);

        // Resync: frame_start lands on slot 4
        ferr_seen = 0;
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, k == 0, 1);
        send_frame(8'hA5, 1, 8'h00, 0);
        check("resync_ferr", 32'(ferr_seen), 32'd1);
        check("resync_out", 32'(out), 32'hA5);
        cycle(0, 0, 0, 1);

        // Overrun
        ovr_seen = 0;
        send_frame(8'h3C, 0, 8'h00, 0);
        send_frame(8'hC3, 0, 8'h00, 0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_out", 32'(out), 32'h3C);
        check("ovr_valid", 32'(out_valid), 32'd1);
        cycle(0, 0, 0, 1);
        check("ovr_count", 32'(ovr_seen), 32'd1);
        check("ovr_drain", 32'(out_valid), 32'd0);

        // Back-to-back consumption
        ferr_seen = 0; ovr_seen = 0;
        send_frame(8'h01, 1, 8'h00, 0);
        check("b2b_0", 32'(out), 32'h01);
        send_frame(8'h80, 1, 8'h00, 0);
        check("b2b_1", 32'(out), 32'h80);
        send_frame(8'hFF, 1, 8'h00, 0);
        check("b2b_2", 32'(out), 32'hFF);
        check("b2b_flags", 32'(ferr_seen + ovr_seen), 32'd0);

        // Reset mid-frame at slot 3 (held word FF still present, not consumed)
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, k == 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({frame_err, overrun}), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1);
        check("stray_slot", 32'(slot), 32'd0);
        send_frame(8'h5A, 1, 8'h00, 0);
        check("post_rst_out", 32'(out), 32'h5A);
        cycle(0, 0, 0, 1);

        // Table-driven frames
        foreach (vecs[i]) begin
            send_frame(vecs[i].word, 1, vecs[i].stall_mask, 2);
            check("vec_out", 32'(out), 32'(vecs[i].exp_out));
            check("vec_valid", 32'(out_valid), 32'd1);
        end
        cycle(0, 0, 0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit bv, fs;
            bv = ($urandom_range(0, 9) < 7);
            fs = (mq.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            cycle(1'($urandom), bv, fs, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_8bit.md
# tdm_demux_8bit

Time-division demultiplexer/deserializer forming the receiving end of the 8:1 mux path. The mux scans `sel` 0..7 and places `in[sel]` on a single line. This block samples that line one slot per accepted bit, steers each bit to the matching position, and presents the rebuilt 8-bit word with a valid/ready handshake. It sits directly downstream of the mux and exports its slot counter so the mux `sel` can be driven from it.

## Interface
- `WIDTH`, default 8: word width and slots per frame; a power of two, at least 2.
- `SEL_W`, default 3: slot counter width, equal to log2(`WIDTH`).

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `serial_in`  in  1  muxed data bit (the mux `out`).
- `bit_valid`  in  1  `serial_in` is sampled this cycle.
- `frame_start`  in  1  qualifies the current bit as slot 0; meaningful only with `bit_valid`.
- `slot`  out  `SEL_W`  slot index expected for the next accepted bit; drives the mux `sel`.
- `out`  out  `WIDTH`  reconstructed word; `out[k]` is the bit received in slot k.
- `out_valid`  out  1  `out` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts `out` when asserted together with `out_valid`.
- `frame_err`  out  1  one-cycle pulse: `frame_start` arrived mid-frame and the partial word was discarded.
- `overrun`  out  1  one-cycle pulse: a word completed while the holding register was full and not being read; the new word was dropped.

## Operation
- Two states: IDLE and COLLECT.
- IDLE
  - `bit_valid & frame_start`: write bit to position 0, set `slot` to 1, go to COLLECT.
  - `bit_valid & !frame_start`: ignore the bit; no flag.
  - `slot` reads 0 in IDLE.
- COLLECT
  - `bit_valid & !frame_start`: write bit to position `slot`, increment `slot`.
  - `bit_valid & frame_start` (any slot 1..`WIDTH`-1, including the last): pulse `frame_err`, clear the partial word, treat this bit as slot 0, set `slot` to 1, stay in COLLECT.
  - `!bit_valid`: stall; hold `slot` and the partial word indefinitely.
- Completion: accepting the bit at slot `WIDTH`-1 completes the frame. `slot` wraps to 0 and the state returns to IDLE.
- Holding register, evaluated at the completion edge:
  - empty (`out_valid`=0): load the word, set `out_valid`.
  - full with `out_ready`=1: the consumed word is replaced by the new one; `out_valid` stays 1.
  - full with `out_ready`=0: keep the old word, pulse `overrun`, drop the new word.
- Without completion, `out_valid & out_ready` clears `out_valid`. `out` keeps its last value.
- `WIDTH`=2 edge case: slot 1 is both the first COLLECT slot and the completing slot.
- No arithmetic beyond the modulo-`WIDTH` slot counter. Wrap is natural `SEL_W`-bit overflow.

## Timing
- Reset values (asynchronous assert, deassert synchronous to `clk`): state IDLE, `slot`=0, `out`=0, `out_valid`=0, `frame_err`=0, `overrun`=0, partial word 0.
- Reset asserted mid-frame discards the partial word and any held word.
- Latency: `out_valid` rises on the edge after the cycle carrying the slot `WIDTH`-1 bit, i.e. 1 cycle after the last bit.
- Throughput: a new frame may start on the cycle immediately after the completing bit. With no stalls that gives one word per `WIDTH` cycles.
- `slot` is registered. The mux `sel` driven from it is valid one cycle ahead of the bit that is sampled.
- `frame_err` and `overrun` are registered and asserted on the edge following the triggering cycle, for exactly one cycle.
- `out` and `out_valid` are registered and never combinationally dependent on `out_ready`.

## Structure
- Shared package/include holds:
  - state encodings `ST_IDLE`=0, `ST_COLLECT`=1;
  - default `WIDTH`/`SEL_W` constants, also used by the mux and its benches.
- One natural sub-module, `tdm_slot_counter`: `SEL_W`-bit counter with synchronous load-to-1 on `frame_start`, enable on `bit_valid`, and a `wrap` output.
- Bit steering, FSM and holding register stay in the top.

## Test plan
- Basic frame: frame 8'b10011010 sent slots 0..7 (`bit_valid`=1, `frame_start` at slot 0, `out_ready`=1) -> `out`=8'b10011010, `out_valid`=1 for one cycle, 1 cycle after slot 7; `slot` sequence 0,1..7,0.
- Stalls: same frame with `bit_valid` low for 3 cycles after slots 2 and 5 -> identical `out`, `slot` frozen during gaps, no flags.
- Resync: `frame_start` with slot 4 bit, followed by full frame 8'hA5 -> `frame_err` pulse once, `out`=8'hA5.
- Overrun: two back-to-back frames 8'h3C then 8'hC3 with `out_ready`=0 -> `out`=8'h3C held, `overrun` pulse 1 cycle after the second frame's slot 7, `out_valid` stays 1. Then assert `out_ready` for one cycle -> `out_valid` drops.
- Back-to-back consumption: frames 8'h01, 8'h80, 8'hFF continuous with `out_ready`=1 -> three words in order, spaced 8 cycles, no flags.
- Reset mid-frame: assert `rst_n`=0 at slot 3 -> all outputs 0 immediately. Stray bits without `frame_start` are ignored. The next full frame 8'h5A decodes correctly.
